// File: rtl/bf_spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : bf_spi_frame_rx
// Brief    : Lane-side SPI mode-0 slave. Oversamples SCLK/CS/MOSI with clk,
//            assembles 40-bit MSB-first frames (cmd, addr16, value16) and
//            queues them in a small FWFT FIFO behind a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module bf_spi_frame_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            spi_sclk,
    input  logic                            spi_cs_n,
    input  logic                            spi_mosi,
    output logic                            frm_valid,
    input  logic                            frm_ready,
    output logic [7:0]                      frm_cmd,
    output logic [15:0]                     frm_addr,
    output logic [15:0]                     frm_value,
    output logic [5:0]                      frm_phase_idx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]                abort_cnt,
    output logic [CNT_W-1:0]                ovf_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [5:0]       c_LAST_BIT = 6'd39;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PUSH  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_q;
    logic                   r_cs_q;

    logic w_s_sclk;
    logic w_s_cs_n;
    logic w_s_mosi;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    // Resolve the asynchronous SPI pins into the clk domain; presets match idle bus levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_q    <= 1'b0;
            r_cs_q      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_q    <= w_s_sclk;
            r_cs_q      <= w_s_cs_n;
        end
    end

    assign w_s_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_s_cs_n    = r_cs_sync[SYNC_STAGES-1];
    assign w_s_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_s_sclk && !r_sclk_q;
    assign w_cs_fall   = !w_s_cs_n && r_cs_q;
    assign w_cs_rise   = w_s_cs_n && !r_cs_q;

    // ------------------------------------------------------------------
    // Frame assembly FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_clr;
    logic        w_shift_en;
    logic        w_abort;
    logic        w_push;
    logic [39:0] r_shift;
    logic [5:0]  r_bit_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes; a CS rise outranks a coincident SCLK edge
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_shift_en  = 1'b0;
        w_abort     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clr = 1'b1;
                if (w_cs_fall) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = (r_bit_cnt != 6'd0);
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = w_s_cs_n ? ST_IDLE : ST_SHIFT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register and bit counter; the completed frame stays in r_shift during PUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_clr) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_abort) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_shift   <= {r_shift[38:0], w_s_mosi};
            r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? 6'd0 : r_bit_cnt + 6'd1;
        end
    end

    // ------------------------------------------------------------------
    // FWFT frame FIFO with a registered head
    // ------------------------------------------------------------------
    logic [39:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [39:0]      r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_full;
    logic             w_wr;
    logic             w_drop;
    logic [LVL_W-1:0] w_level_nxt;
    logic [PTR_W-1:0] w_rd_nxt;
    logic             w_bypass;

    assign w_pop       = r_valid && frm_ready;
    assign w_full      = (r_level == c_LVL_FULL);
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_drop      = w_push && !w_wr;
    assign w_level_nxt = r_level + LVL_W'(w_wr) - LVL_W'(w_pop);
    assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
    // The new head is the frame being written whenever no older entry survives this cycle
    assign w_bypass    = w_wr && (r_level == LVL_W'(w_pop));

    // Storage array; holds no control state so it needs no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Pointers, occupancy and the registered head; head holds its value when the FIFO drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_level_nxt;
            r_valid  <= (w_level_nxt != '0);
            if (w_level_nxt != '0) begin
                r_head <= w_bypass ? r_shift : r_mem[w_rd_nxt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_abort_cnt;
    logic [CNT_W-1:0] r_ovf_cnt;

    // Count truncated and dropped frames, pinning at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_cnt <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (w_abort && (r_abort_cnt != '1)) begin
                r_abort_cnt <= r_abort_cnt + CNT_W'(1);
            end
            if (w_drop && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frm_valid     = r_valid;
    assign frm_cmd       = r_head[39:32];
    assign frm_addr      = r_head[31:16];
    assign frm_value     = r_head[15:0];
    assign frm_phase_idx = r_head[15:10];
    assign busy          = !w_s_cs_n || (r_state == ST_PUSH);
    assign fifo_level    = r_level;
    assign abort_cnt     = r_abort_cnt;
    assign ovf_cnt       = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bf_spi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_spi_frame_rx
// Brief    : Directed self-checking bench for bf_spi_frame_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bf_spi_frame_rx;

    logic        clk;
    logic        rst_n;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        frm_valid;
    logic        frm_ready;
    logic [7:0]  frm_cmd;
    logic [15:0] frm_addr;
    logic [15:0] frm_value;
    logic [5:0]  frm_phase_idx;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [7:0]  abort_cnt;
    logic [7:0]  ovf_cnt;

    int total = 0;
    int bad   = 0;

    logic [39:0] got [$];
    logic [5:0]  gph [$];

    bf_spi_frame_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .frm_valid     (frm_valid),
        .frm_ready     (frm_ready),
        .frm_cmd       (frm_cmd),
        .frm_addr      (frm_addr),
        .frm_value     (frm_value),
        .frm_phase_idx (frm_phase_idx),
        .busy          (busy),
        .fifo_level    (fifo_level),
        .abort_cnt     (abort_cnt),
        .ovf_cnt       (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every frame handed to the consumer
    always @(posedge clk) begin
        if (rst_n && frm_valid && frm_ready) begin
            got.push_back({frm_cmd, frm_addr, frm_value});
            gph.push_back(frm_phase_idx);
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit_head(input logic b);
        @(negedge clk);
        spi_mosi = b;
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
    endtask

    task automatic bit_tail();
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_bit(input logic b);
        bit_head(b);
        bit_tail();
    endtask

    task automatic send_frame(input logic [39:0] f);
        for (int i = 39; i >= 0; i--) spi_bit(f[i]);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [39:0] f;
        logic [15:0] bvals [3];
        logic [5:0]  bph   [3];
        int          base;

        bvals = '{16'h0400, 16'h0800, 16'hFC00};
        bph   = '{6'd1, 6'd2, 6'd63};

        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        frm_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 40'(frm_valid), 40'd0);
        chk("rst_level", 40'(fifo_level), 40'd0);
        chk("rst_abort", 40'(abort_cnt), 40'd0);
        chk("rst_ovf",   40'(ovf_cnt), 40'd0);
        chk("rst_busy",  40'(busy), 40'd0);
        chk("rst_head",  {frm_cmd, frm_addr, frm_value}, 40'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame with latency check on the last bit
        f = 40'h02_0015_A800;
        cs_low();
        chk("t1_busy_cs", 40'(busy), 40'd1);
        for (int i = 39; i >= 1; i--) spi_bit(f[i]);
        bit_head(f[0]);
        repeat (3) @(posedge clk);
        #1 chk("t1_valid_early", 40'(frm_valid), 40'd0);
        @(posedge clk);
        #1 chk("t1_valid_n2", 40'(frm_valid), 40'd1);
        bit_tail();
        chk("t1_cmd",   40'(frm_cmd), 40'h02);
        chk("t1_addr",  40'(frm_addr), 40'h0015);
        chk("t1_value", 40'(frm_value), 40'hA800);
        chk("t1_phase", 40'(frm_phase_idx), 40'd42);
        chk("t1_level", 40'(fifo_level), 40'd1);
        chk("t1_abort", 40'(abort_cnt), 40'd0);
        cs_high();
        chk("t1_busy_idle", 40'(busy), 40'd0);
        @(negedge clk) frm_ready = 1'b1;
        @(negedge clk) frm_ready = 1'b0;
        chk("t1_pop_valid", 40'(frm_valid), 40'd0);
        chk("t1_pop_level", 40'(fifo_level), 40'd0);

        // Burst of three frames under one CS, consumer always ready
        base = got.size();
        frm_ready = 1'b1;
        cs_low();
        for (int k = 0; k < 3; k++) send_frame({8'h10, 16'(k + 1), bvals[k]});
        cs_high();
        repeat (10) @(negedge clk);
        chk("t2_count", 40'(got.size() - base), 40'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_frame%0d", k), got[base + k], {8'h10, 16'(k + 1), bvals[k]});
            chk($sformatf("t2_phase%0d", k), 40'(gph[base + k]), 40'(bph[k]));
        end
        chk("t2_level", 40'(fifo_level), 40'd0);
        frm_ready = 1'b0;

        // Overflow: six frames into a four-deep FIFO with no consumer
        base = got.size();
        cs_low();
        for (int i = 1; i <= 6; i++) send_frame({8'(8'h20 + i), 16'(i), 16'(16'h1111 * i)});
        cs_high();
        chk("t3_level", 40'(fifo_level), 40'd4);
        chk("t3_ovf",   40'(ovf_cnt), 40'd2);
        chk("t3_head",  40'(frm_value), 40'h1111);
        @(negedge clk) frm_ready = 1'b1;
        repeat (10) @(negedge clk);
        frm_ready = 1'b0;
        chk("t3_count", 40'(got.size() - base), 40'd4);
        for (int i = 1; i <= 4; i++)
            chk($sformatf("t3_frame%0d", i), got[base + i - 1], {8'(8'h20 + i), 16'(i), 16'(16'h1111 * i)});
        chk("t3_level_drained", 40'(fifo_level), 40'd0);

        // Abort after 17 bits, then a complete frame
        base = got.size();
        frm_ready = 1'b1;
        f = 40'hFF_FFFF_FFFF;
        cs_low();
        for (int i = 39; i >= 23; i--) spi_bit(f[i]);
        cs_high();
        chk("t4_abort", 40'(abort_cnt), 40'd1);
        chk("t4_level", 40'(fifo_level), 40'd0);
        cs_low();
        send_frame(40'h01_1234_5678);
        cs_high();
        repeat (10) @(negedge clk);
        chk("t4_count", 40'(got.size() - base), 40'd1);
        chk("t4_frame", got[base], 40'h01_1234_5678);
        chk("t4_abort_after", 40'(abort_cnt), 40'd1);
        frm_ready = 1'b0;

        // Full FIFO with a pop landing exactly in the push cycle
        base = got.size();
        cs_low();
        for (int i = 1; i <= 4; i++) send_frame({8'h30, 16'(i), 16'(16'h0A00 + i)});
        chk("t5_full", 40'(fifo_level), 40'd4);
        f = {8'h30, 16'd5, 16'h0A05};
        for (int i = 39; i >= 1; i--) spi_bit(f[i]);
        bit_head(f[0]);
        repeat (3) @(negedge clk);
        frm_ready = 1'b1;
        @(negedge clk);
        frm_ready = 1'b0;
        bit_tail();
        chk("t5_level", 40'(fifo_level), 40'd4);
        chk("t5_ovf",   40'(ovf_cnt), 40'd2);
        chk("t5_popped", 40'(got.size() - base), 40'd1);
        chk("t5_head_a", {frm_cmd, frm_addr, frm_value}, 40'h30_0002_0A02);
        repeat (10) @(negedge clk);
        chk("t5_head_b", {frm_cmd, frm_addr, frm_value}, 40'h30_0002_0A02);
        chk("t5_valid",  40'(frm_valid), 40'd1);
        cs_high();
        frm_ready = 1'b1;
        repeat (12) @(negedge clk);
        frm_ready = 1'b0;
        chk("t5_count", 40'(got.size() - base), 40'd5);
        for (int i = 1; i <= 5; i++)
            chk($sformatf("t5_frame%0d", i), got[base + i - 1], {8'h30, 16'(i), 16'(16'h0A00 + i)});

        // Asynchronous reset in the middle of a frame
        f = 40'h66_7777_8888;
        cs_low();
        send_frame(40'h11_2222_3333);
        chk("t6_pre_valid", 40'(frm_valid), 40'd1);
        for (int i = 39; i >= 20; i--) spi_bit(f[i]);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_valid", 40'(frm_valid), 40'd0);
        chk("t6_level", 40'(fifo_level), 40'd0);
        chk("t6_head",  {frm_cmd, frm_addr, frm_value}, 40'd0);
        chk("t6_phase", 40'(frm_phase_idx), 40'd0);
        chk("t6_ovf",   40'(ovf_cnt), 40'd0);
        chk("t6_abort", 40'(abort_cnt), 40'd0);
        chk("t6_busy",  40'(busy), 40'd0);
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        base = got.size();
        frm_ready = 1'b1;
        cs_low();
        send_frame(40'hA5_BEEF_1234);
        cs_high();
        repeat (10) @(negedge clk);
        chk("t6_count", 40'(got.size() - base), 40'd1);
        chk("t6_frame", got[base], 40'hA5_BEEF_1234);
        chk("t6_abort_after", 40'(abort_cnt), 40'd0);
        chk("t6_level_after", 40'(fifo_level), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bf_spi_frame_rx.md
Name: bf_spi_frame_rx

Overview:
- Lane-side SPI slave for the beamformer. One instance sits downstream of each beamformer_top SPI lane (spi_sclk/spi_cs_n/spi_mosi).
- Oversamples SPI mode 0 with the system clock and assembles 5-byte MSB-first frames: b0 = cmd, b1..b2 = addr, b3..b4 = value16.
- Decoded frames are buffered in a small FWFT FIFO and offered on a valid/ready port to the element register bank.

Parameters:
- FIFO_DEPTH, 4, frame FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi; minimum 2.
- CNT_W, 8, width of the saturating error counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- spi_sclk  in  1  SPI clock, asynchronous to clk, idle low.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data, MSB first.
- frm_valid  out  1  FIFO head holds a frame.
- frm_ready  in  1  consumer accepts the head frame.
- frm_cmd  out  8  head frame b0.
- frm_addr  out  16  head frame {b1,b2}.
- frm_value  out  16  head frame {b3,b4}.
- frm_phase_idx  out  6  frm_value[15:10].
- busy  out  1  CS low (synchronized) or push pending.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- abort_cnt  out  CNT_W  count of frames truncated by CS deassertion.
- ovf_cnt  out  CNT_W  count of frames dropped because the FIFO was full.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset: all outputs 0, FIFO empty, synchronizers preset (sclk=0, cs_n=1, mosi=0), state IDLE, counters 0.
- Clocking constraint: clk ≥ 4× sclk, with each sclk phase lasting at least 2 clk periods. Synchronized SCLK rising edges are therefore at least 4 clk cycles apart.
- Input path: every input passes through SYNC_STAGES flops. A rising edge is detected as s_sclk && !s_sclk_q. CS transitions are detected the same way on s_cs_n.
- IDLE:
  - bit_cnt = 0, shift register cleared.
  - s_cs_n falling edge -> SHIFT.
- SHIFT:
  - On each detected sclk rising edge, shift s_mosi into a 40-bit register LSB-side (MSB first on the wire) and increment bit_cnt (0..39).
  - When the 40th bit is captured -> PUSH, with bit_cnt reset to 0.
  - s_cs_n rising edge with bit_cnt != 0 -> discard the partial frame, increment abort_cnt (saturating), go to IDLE.
  - s_cs_n rising edge with bit_cnt == 0 -> go to IDLE, no error.
- PUSH (exactly 1 cycle):
  - FIFO not full, or full with frm_ready && frm_valid in the same cycle -> write the frame.
  - Otherwise drop the frame and increment ovf_cnt (saturating).
  - Next state: SHIFT if s_cs_n is low, else IDLE. Back-to-back frames under one CS are supported.
  - A CS rise seen during PUSH is honoured on the following cycle; the completed frame is still pushed.
- FIFO:
  - FWFT, registered outputs. A frame written at PUSH cycle T is visible with frm_valid=1 at T+1 if the FIFO was empty.
  - Pop on frm_valid && frm_ready. Head fields are stable while frm_valid && !frm_ready.
  - fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
- Latency, empty FIFO: the detected 40th sclk edge at cycle N gives frm_valid=1 at N+2.
- frm_phase_idx is combinational from registered frm_value. frm_* outputs hold their last value when the FIFO is empty, but consumers must qualify them with frm_valid.
- busy = !s_cs_n || state==PUSH.
- Counters saturate at 2^CNT_W−1 and never wrap. They clear only on reset.
- Reset asserted mid-frame: immediate clear; the partial frame is lost and not counted as an abort.

Test Plan:
- Single frame: one CS window carrying 0x02,0x00,0x15,0xA8,0x00 -> one frm_valid with cmd=0x02, addr=0x0015, value=0xA800, phase_idx=42; frm_valid rises 2 clk after the synced 40th edge; abort_cnt=0.
- Burst under one CS: 3 frames, value16 = 0x0400, 0x0800, 0xFC00, frm_ready=1 -> delivered in order with phase_idx 1, 2, 63; fifo_level returns to 0.
- Overflow: frm_ready=0, 6 frames sent with FIFO_DEPTH=4 -> fifo_level=4, ovf_cnt=2, and the first 4 frames pop out intact once ready is raised.
- Abort: CS deasserted after 17 bits, followed by a full frame 0x01,0x12,0x34,0x56,0x78 -> abort_cnt=1 and exactly one frame delivered, value=0x5678.
- Ready toggling with push and pop in the same cycle at full -> no overflow counted, data order preserved, head fields stable while stalled.
- Async reset asserted mid-frame (bit 20) -> all outputs 0 immediately; the next full frame is received correctly and abort_cnt stays 0.
